ball_motion_ctrl: RTL and testbench

- Owns the ball position (x_ball, y_ball) for the maze demo and feeds it to the maze collision/drawing stage.
- Once per video frame, steps the ball up to `speed` pixels in the requested direction(s), one pixel per axis at a time.
- After each pixel it re-samples the collision stage's stop_right/left/up/down flags. Those flags are exact-equality edge tests, so single-pixel steps are mandatory.
- Also clamps the ball to the playfield, detects the goal region and supports restart to the start position.

---
 rtl/maze_pkg.sv | 25 ++
 rtl/ball_axis_step.sv | 27 ++
 rtl/ball_motion_ctrl.sv | 151 +++++++++++++++
 tb/tb_ball_motion_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared maze-demo constants and the ball stepping FSM state type.
// Also used by the maze drawing/collision stage.
package maze_pkg;

   localparam int COORD_W    = 11;
   localparam int SCREEN_W   = 640;
   localparam int SCREEN_H   = 480;
   localparam int BALL_W_DEF = 8;

   localparam int MAZE_X_START  = 70;
   localparam int MAZE_Y_START  = 35;
   localparam int MAZE_GOAL_X0  = 500;
   localparam int MAZE_GOAL_X1  = 600;
   localparam int MAZE_GOAL_Y0  = 40;
   localparam int MAZE_GOAL_Y1  = 70;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MOVE_X,
      ST_SETTLE_X,
      ST_MOVE_Y,
      ST_SETTLE_Y
   } ball_state_t;

endpackage

// File: rtl/ball_axis_step.sv
// Single-axis one-pixel step: moves pos by +/-1 when exactly one direction is
// requested, that side is not blocked, and the bound has not been reached.
module ball_axis_step
   import maze_pkg::*;
(
   input  logic [COORD_W-1:0] pos,
   input  logic               inc_req,
   input  logic               dec_req,
   input  logic               stop_inc,
   input  logic               stop_dec,
   input  logic [COORD_W-1:0] pos_min,
   input  logic [COORD_W-1:0] pos_max,
   output logic [COORD_W-1:0] next_pos
);

   localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

   always_comb begin
      next_pos = pos;
      if (inc_req && !dec_req && !stop_inc && (pos < pos_max)) begin
         next_pos = pos + ONE;
      end else if (dec_req && !inc_req && !stop_dec && (pos > pos_min)) begin
         next_pos = pos - ONE;
      end
   end

endmodule

// File: rtl/ball_motion_ctrl.sv
// Per-frame ball mover: steps up to `speed` pixels per axis, one pixel at a time,
// re-sampling the collision flags after each settled step; tracks the goal.
module ball_motion_ctrl
   import maze_pkg::*;
#(
   parameter int BALL_W  = BALL_W_DEF,
   parameter int X_START = MAZE_X_START,
   parameter int Y_START = MAZE_Y_START,
   parameter int X_MIN   = 0,
   parameter int X_MAX   = SCREEN_W - 1,
   parameter int Y_MIN   = 0,
   parameter int Y_MAX   = SCREEN_H - 1,
   parameter int GOAL_X0 = MAZE_GOAL_X0,
   parameter int GOAL_X1 = MAZE_GOAL_X1,
   parameter int GOAL_Y0 = MAZE_GOAL_Y0,
   parameter int GOAL_Y1 = MAZE_GOAL_Y1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_tick,
   input  logic        restart,
   input  logic        req_right,
   input  logic        req_left,
   input  logic        req_up,
   input  logic        req_down,
   input  logic [2:0]  speed,
   input  logic        stop_right,
   input  logic        stop_left,
   input  logic        stop_up,
   input  logic        stop_down,
   output logic [10:0] x_ball,
   output logic [10:0] y_ball,
   output logic [4:0]  ball_width,
   output logic        busy,
   output logic        goal_reached
);

   localparam int EXT_W = COORD_W + 1;

   localparam logic [COORD_W-1:0] X_LO   = COORD_W'(X_MIN);
   localparam logic [COORD_W-1:0] X_HI   = COORD_W'(X_MAX - BALL_W + 1);
   localparam logic [COORD_W-1:0] Y_LO   = COORD_W'(Y_MIN);
   localparam logic [COORD_W-1:0] Y_HI   = COORD_W'(Y_MAX - BALL_W + 1);
   localparam logic [COORD_W-1:0] X_INIT = COORD_W'(X_START);
   localparam logic [COORD_W-1:0] Y_INIT = COORD_W'(Y_START);
   localparam logic [EXT_W-1:0]   EDGE   = EXT_W'(BALL_W - 1);

   ball_state_t        state, state_nxt;
   logic [2:0]         steps_left;
   logic               dir_r, dir_l, dir_u, dir_d;
   logic [COORD_W-1:0] x_nxt, y_nxt;
   logic               goal_hit;

   assign ball_width = 5'(BALL_W);
   assign busy       = (state != ST_IDLE);

   ball_axis_step u_step_x (
      .pos      (x_ball),
      .inc_req  (dir_r),
      .dec_req  (dir_l),
      .stop_inc (stop_right),
      .stop_dec (stop_left),
      .pos_min  (X_LO),
      .pos_max  (X_HI),
      .next_pos (x_nxt)
   );

   ball_axis_step u_step_y (
      .pos      (y_ball),
      .inc_req  (dir_d),
      .dec_req  (dir_u),
      .stop_inc (stop_down),
      .stop_dec (stop_up),
      .pos_min  (Y_LO),
      .pos_max  (Y_HI),
      .next_pos (y_nxt)
   );

   // Widened by one bit so the right/bottom edge sum cannot wrap.
   assign goal_hit = (({1'b0, x_ball} + EDGE) >= EXT_W'(GOAL_X0)) &&
                     (x_ball <= COORD_W'(GOAL_X1)) &&
                     (({1'b0, y_ball} + EDGE) >= EXT_W'(GOAL_Y0)) &&
                     (y_ball <= COORD_W'(GOAL_Y1));

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (frame_tick && !goal_reached && (speed != 3'd0)) begin
               state_nxt = ST_MOVE_X;
            end
         end
         ST_MOVE_X:   state_nxt = ST_SETTLE_X;
         ST_SETTLE_X: state_nxt = ST_MOVE_Y;
         ST_MOVE_Y:   state_nxt = ST_SETTLE_Y;
         ST_SETTLE_Y: begin
            if ((steps_left == 3'd1) || goal_reached) begin
               state_nxt = ST_IDLE;
            end else begin
               state_nxt = ST_MOVE_X;
            end
         end
         default:     state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || restart) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Position moves only in the MOVE states, so stop flags are never sampled
   // while the collision stage is still settling.
   always_ff @(posedge clk) begin
      if (rst || restart) begin
         x_ball       <= X_INIT;
         y_ball       <= Y_INIT;
         goal_reached <= 1'b0;
         steps_left   <= 3'd0;
         dir_r        <= 1'b0;
         dir_l        <= 1'b0;
         dir_u        <= 1'b0;
         dir_d        <= 1'b0;
      end else begin
         goal_reached <= goal_reached | goal_hit;
         case (state)
            ST_IDLE: begin
               if (state_nxt == ST_MOVE_X) begin
                  steps_left <= speed;
                  dir_r      <= req_right;
                  dir_l      <= req_left;
                  dir_u      <= req_up;
                  dir_d      <= req_down;
               end
            end
            ST_MOVE_X: begin
               if (!goal_reached) x_ball <= x_nxt;
            end
            ST_MOVE_Y: begin
               if (!goal_reached) y_ball <= y_nxt;
            end
            ST_SETTLE_Y: steps_left <= steps_left - 3'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Directed bench for ball_motion_ctrl: idle, free move, wall, diagonal,
// playfield bounds, goal detection and restart.
module tb_ball_motion_ctrl;

   logic        clk = 1'b0;
   logic        rst, frame_tick, restart;
   logic        req_right, req_left, req_up, req_down;
   logic [2:0]  speed;
   logic        stop_right, stop_left, stop_up, stop_down;
   logic [10:0] x_ball, y_ball;
   logic [4:0]  ball_width;
   logic        busy, goal_reached;
   logic        wall_en;

   int tests_run    = 0;
   int tests_failed = 0;
   int cyc;

   always #5 clk = ~clk;

   // Maze stand-in: a wall whose left face is at x=80.
   assign stop_right = wall_en && ((x_ball + 11'd8) == 11'd80);
   assign stop_left  = 1'b0;
   assign stop_up    = 1'b0;
   assign stop_down  = 1'b0;

   ball_motion_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .frame_tick   (frame_tick),
      .restart      (restart),
      .req_right    (req_right),
      .req_left     (req_left),
      .req_up       (req_up),
      .req_down     (req_down),
      .speed        (speed),
      .stop_right   (stop_right),
      .stop_left    (stop_left),
      .stop_up      (stop_up),
      .stop_down    (stop_down),
      .x_ball       (x_ball),
      .y_ball       (y_ball),
      .ball_width   (ball_width),
      .busy         (busy),
      .goal_reached (goal_reached)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
      end
   endtask

   // One frame: tick with the given request, then count busy cycles (bounded).
   task automatic do_frame(input logic r, input logic l, input logic u, input logic d,
                           input logic [2:0] spd, output int n);
      req_right = r; req_left = l; req_up = u; req_down = d; speed = spd;
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (n >= 200) check("busy_timeout", 32'(n), 32'd0);
   endtask

   task automatic pulse_restart();
      @(negedge clk) restart = 1'b1;
      @(negedge clk) restart = 1'b0;
   endtask

   initial begin
      int d;
      rst = 1'b1; frame_tick = 1'b0; restart = 1'b0; wall_en = 1'b0;
      req_right = 1'b0; req_left = 1'b0; req_up = 1'b0; req_down = 1'b0; speed = 3'd0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      check("rst_x", 32'(x_ball), 32'd70);
      check("rst_y", 32'(y_ball), 32'd35);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_goal", 32'(goal_reached), 32'd0);
      check("ball_width", 32'(ball_width), 32'd8);

      for (int i = 0; i < 3; i++) do_frame(1'b0, 1'b0, 1'b0, 1'b0, 3'd3, cyc);
      check("idle_x", 32'(x_ball), 32'd70);
      check("idle_y", 32'(y_ball), 32'd35);

      do_frame(1'b1, 1'b0, 1'b0, 1'b0, 3'd5, cyc);
      check("free_busy_cycles", 32'(cyc), 32'd20);
      check("free_x", 32'(x_ball), 32'd75);
      check("free_y", 32'(y_ball), 32'd35);

      do_frame(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, cyc);
      check("speed0_busy", 32'(cyc), 32'd0);
      check("speed0_x", 32'(x_ball), 32'd75);

      pulse_restart();
      check("restart_x", 32'(x_ball), 32'd70);
      wall_en = 1'b1;
      do_frame(1'b1, 1'b0, 1'b0, 1'b0, 3'd7, cyc);
      check("wall_busy_cycles", 32'(cyc), 32'd28);
      check("wall_x", 32'(x_ball), 32'd72);
      do_frame(1'b1, 1'b0, 1'b0, 1'b0, 3'd7, cyc);
      check("wall_x_again", 32'(x_ball), 32'd72);
      wall_en = 1'b0;

      pulse_restart();
      do_frame(1'b1, 1'b0, 1'b0, 1'b1, 3'd3, cyc);
      check("diag_x", 32'(x_ball), 32'd73);
      check("diag_y", 32'(y_ball), 32'd38);
      do_frame(1'b1, 1'b1, 1'b1, 1'b0, 3'd2, cyc);
      check("opp_x", 32'(x_ball), 32'd73);
      check("opp_y", 32'(y_ball), 32'd36);

      // Drop below the goal rows, then run to the right bound.
      for (int i = 0; i < 100 && y_ball < 11'd100; i++) begin
         d = 100 - int'(y_ball);
         do_frame(1'b0, 1'b0, 1'b0, 1'b1, 3'(d > 7 ? 7 : d), cyc);
      end
      check("travel_y100", 32'(y_ball), 32'd100);
      for (int i = 0; i < 200 && x_ball < 11'd632; i++) begin
         d = 632 - int'(x_ball);
         do_frame(1'b1, 1'b0, 1'b0, 1'b0, 3'(d > 7 ? 7 : d), cyc);
      end
      check("travel_x632", 32'(x_ball), 32'd632);
      do_frame(1'b1, 1'b0, 1'b0, 1'b0, 3'd4, cyc);
      check("xmax_busy", 32'(cyc), 32'd16);
      check("xmax_x", 32'(x_ball), 32'd632);

      for (int i = 0; i < 100 && y_ball > 11'd0; i++) begin
         d = int'(y_ball);
         do_frame(1'b0, 1'b0, 1'b1, 1'b0, 3'(d > 7 ? 7 : d), cyc);
      end
      check("travel_y0", 32'(y_ball), 32'd0);
      do_frame(1'b0, 1'b0, 1'b1, 1'b0, 3'd4, cyc);
      check("ymin_y", 32'(y_ball), 32'd0);
      check("ymin_x", 32'(x_ball), 32'd632);

      // Approach the goal from the left at y=35 (inside the goal rows).
      for (int i = 0; i < 100 && x_ball > 11'd491; i++) begin
         d = int'(x_ball) - 491;
         do_frame(1'b0, 1'b1, 1'b0, 1'b0, 3'(d > 7 ? 7 : d), cyc);
      end
      for (int i = 0; i < 100 && y_ball < 11'd35; i++) begin
         d = 35 - int'(y_ball);
         do_frame(1'b0, 1'b0, 1'b0, 1'b1, 3'(d > 7 ? 7 : d), cyc);
      end
      check("pregoal_x", 32'(x_ball), 32'd491);
      check("pregoal_y", 32'(y_ball), 32'd35);
      check("pregoal_goal", 32'(goal_reached), 32'd0);

      do_frame(1'b1, 1'b0, 1'b0, 1'b0, 3'd7, cyc);
      check("goal_flag", 32'(goal_reached), 32'd1);
      check("goal_x", 32'(x_ball), 32'd493);
      check("goal_busy_cycles", 32'(cyc), 32'd8);
      do_frame(1'b1, 1'b0, 1'b0, 1'b0, 3'd7, cyc);
      check("goal_tick_busy", 32'(cyc), 32'd0);
      check("goal_hold_x", 32'(x_ball), 32'd493);

      // Restart and frame tick together: restart wins.
      @(negedge clk) begin restart = 1'b1; frame_tick = 1'b1; end
      @(negedge clk) begin restart = 1'b0; frame_tick = 1'b0; end
      check("rs_x", 32'(x_ball), 32'd70);
      check("rs_y", 32'(y_ball), 32'd35);
      check("rs_goal", 32'(goal_reached), 32'd0);
      check("rs_busy", 32'(busy), 32'd0);
      @(negedge clk);
      check("rs_busy_later", 32'(busy), 32'd0);
      check("rs_x_later", 32'(x_ball), 32'd70);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
